// File: rtl/adaptive_threshold_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : adaptive_threshold_engine
// Description : Streams one frame out of a pixel SRAM, compares every pixel
//               against the running mean of a short same-row window plus an
//               offset C, and writes a binary (0 / all-ones) result per pixel
//               into a result SRAM. Read-to-write latency is two cycles.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   Clk            clock, rising edge
//   Rst            asynchronous active-low reset
//   Go, Thr_C, Inv start request, offset C, inverse-output mode
//   P_Addr, P_Data, I_RW, I_En   pixel SRAM port (read only)
//   B_Addr, T_Out, O_RW, O_En    result SRAM port (write only)
//   Busy, Done     frame in progress / one-cycle completion pulse
//   Fg_Count       foreground write count (only with ATH_FGCOUNT_EN)
// Optional feature macro: ATH_FGCOUNT_EN
// ============================================================================
module adaptive_threshold_engine #(
    parameter int IMG_W   = 320,
    parameter int IMG_H   = 240,
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 17,
    parameter int LOG_WIN = 3
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Go,
    input  logic [D_WIDTH-1:0] Thr_C,
    input  logic               Inv,
    output logic [A_WIDTH-1:0] P_Addr,
    input  logic [D_WIDTH-1:0] P_Data,
    output logic               I_RW,
    output logic               I_En,
    output logic [A_WIDTH-1:0] B_Addr,
    output logic [D_WIDTH-1:0] T_Out,
    output logic               O_RW,
    output logic               O_En,
    output logic               Busy,
    output logic               Done
`ifdef ATH_FGCOUNT_EN
    ,
    output logic [A_WIDTH-1:0] Fg_Count
`endif
);

    localparam int WIN   = 1 << LOG_WIN;
    localparam int SUM_W = D_WIDTH + LOG_WIN;
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    // Control and read-address stage
    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] p_addr_q, p_addr_d;
    logic               i_en_q, i_en_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [D_WIDTH-1:0] thr_c_q, thr_c_d;
    logic               inv_q, inv_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Data-return stage: describes the pixel arriving on P_Data this cycle
    logic               rd_vld_q, rd_vld_d;
    logic               rd_col0_q, rd_col0_d;
    logic               rd_last_q, rd_last_d;
    logic [A_WIDTH-1:0] rd_addr_q, rd_addr_d;

    // Window state and write stage
    logic [D_WIDTH-1:0] win_q [WIN];
    logic [D_WIDTH-1:0] win_d [WIN];
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [A_WIDTH-1:0] b_addr_q, b_addr_d;
    logic [D_WIDTH-1:0] t_out_q, t_out_d;
    logic               o_en_q, o_en_d;
    logic               wr_last_q, wr_last_d;
`ifdef ATH_FGCOUNT_EN
    logic [A_WIDTH-1:0] fg_count_q, fg_count_d;
`endif

    logic               w_last_pix;
    logic [SUM_W-1:0]   w_sum_new;
    logic [D_WIDTH-1:0] w_mean;
    logic               w_fg;

    assign w_last_pix = (col_q == COL_W'(IMG_W - 1)) && (row_q == ROW_W'(IMG_H - 1));

    // Window arithmetic on the returning pixel. A row start fills the whole
    // window with the first pixel, so the mean there equals that pixel.
    always_comb begin
        if (rd_col0_q) begin
            w_sum_new = {{LOG_WIN{1'b0}}, P_Data} << LOG_WIN;
        end else begin
            // Intermediate wrap is harmless: the true result always fits SUM_W.
            w_sum_new = sum_q + SUM_W'(P_Data) - SUM_W'(win_q[WIN-1]);
        end
        w_mean = w_sum_new[SUM_W-1:LOG_WIN];
        // One extra bit so p + C cannot overflow.
        w_fg   = ({1'b0, P_Data} + {1'b0, thr_c_q}) > {1'b0, w_mean};
    end

    always_comb begin
        state_d   = state_q;
        p_addr_d  = p_addr_q;
        i_en_d    = i_en_q;
        col_d     = col_q;
        row_d     = row_q;
        thr_c_d   = thr_c_q;
        inv_d     = inv_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        rd_vld_d  = i_en_q;
        rd_col0_d = (col_q == '0);
        rd_last_d = i_en_q & w_last_pix;
        rd_addr_d = p_addr_q;

        win_d     = win_q;
        sum_d     = sum_q;
        b_addr_d  = b_addr_q;
        t_out_d   = t_out_q;
        o_en_d    = 1'b0;
        wr_last_d = 1'b0;
`ifdef ATH_FGCOUNT_EN
        fg_count_d = fg_count_q;
`endif

        if (rd_vld_q) begin
            sum_d = w_sum_new;
            if (rd_col0_q) begin
                for (int i = 0; i < WIN; i++) begin
                    win_d[i] = P_Data;
                end
            end else begin
                for (int i = WIN - 1; i > 0; i--) begin
                    win_d[i] = win_q[i-1];
                end
                win_d[0] = P_Data;
            end
            o_en_d    = 1'b1;
            b_addr_d  = rd_addr_q;
            t_out_d   = (w_fg ^ inv_q) ? {D_WIDTH{1'b1}} : {D_WIDTH{1'b0}};
            wr_last_d = rd_last_q;
`ifdef ATH_FGCOUNT_EN
            fg_count_d = fg_count_q + {{(A_WIDTH-1){1'b0}}, w_fg};
`endif
        end

        case (state_q)
            S_IDLE: begin
                if (Go) begin
                    state_d  = S_RUN;
                    p_addr_d = '0;
                    i_en_d   = 1'b1;
                    col_d    = '0;
                    row_d    = '0;
                    thr_c_d  = Thr_C;
                    inv_d    = Inv;
                    busy_d   = 1'b1;
`ifdef ATH_FGCOUNT_EN
                    fg_count_d = '0;
`endif
                end
            end
            S_RUN: begin
                if (col_q == COL_W'(IMG_W - 1)) begin
                    col_d = '0;
                    row_d = (row_q == ROW_W'(IMG_H - 1)) ? '0 : row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
                if (w_last_pix) begin
                    // P_Addr stays on the last address once reads stop.
                    state_d = S_FLUSH;
                    i_en_d  = 1'b0;
                end else begin
                    p_addr_d = p_addr_q + 1'b1;
                end
            end
            S_FLUSH: begin
                // The final result is on the write port this cycle.
                if (wr_last_q) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                i_en_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= S_IDLE;
            p_addr_q  <= '0;
            i_en_q    <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            thr_c_q   <= '0;
            inv_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_col0_q <= 1'b0;
            rd_last_q <= 1'b0;
            rd_addr_q <= '0;
            for (int i = 0; i < WIN; i++) begin
                win_q[i] <= '0;
            end
            sum_q     <= '0;
            b_addr_q  <= '0;
            t_out_q   <= '0;
            o_en_q    <= 1'b0;
            wr_last_q <= 1'b0;
`ifdef ATH_FGCOUNT_EN
            fg_count_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            p_addr_q  <= p_addr_d;
            i_en_q    <= i_en_d;
            col_q     <= col_d;
            row_q     <= row_d;
            thr_c_q   <= thr_c_d;
            inv_q     <= inv_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_vld_q  <= rd_vld_d;
            rd_col0_q <= rd_col0_d;
            rd_last_q <= rd_last_d;
            rd_addr_q <= rd_addr_d;
            for (int i = 0; i < WIN; i++) begin
                win_q[i] <= win_d[i];
            end
            sum_q     <= sum_d;
            b_addr_q  <= b_addr_d;
            t_out_q   <= t_out_d;
            o_en_q    <= o_en_d;
            wr_last_q <= wr_last_d;
`ifdef ATH_FGCOUNT_EN
            fg_count_q <= fg_count_d;
`endif
        end
    end

    assign P_Addr = p_addr_q;
    assign I_En   = i_en_q;
    assign I_RW   = 1'b0;
    assign B_Addr = b_addr_q;
    assign T_Out  = t_out_q;
    assign O_En   = o_en_q;
    assign O_RW   = o_en_q;
    assign Busy   = busy_q;
    assign Done   = done_q;
`ifdef ATH_FGCOUNT_EN
    assign Fg_Count = fg_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adaptive_threshold_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_adaptive_threshold_engine
// Description : Scoreboard bench for adaptive_threshold_engine on an 8x2
//               frame with a 4-pixel window. Stimulus computes expected
//               writes, Busy/read windows and the Done cycle from a direct
//               arithmetic model; a negedge monitor compares.
// Revision    : 1.0 - initial release
// Optional feature macro: ATH_FGCOUNT_EN (Fg_Count checks)
// ============================================================================
module tb_adaptive_threshold_engine;

    localparam int IMG_W   = 8;
    localparam int IMG_H   = 2;
    localparam int D_WIDTH = 8;
    localparam int A_WIDTH = 17;
    localparam int LOG_WIN = 2;
    localparam int N       = IMG_W * IMG_H;
    localparam int WIN     = 1 << LOG_WIN;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               go;
    logic [D_WIDTH-1:0] thr_c;
    logic               inv;
    logic [A_WIDTH-1:0] p_addr;
    logic [D_WIDTH-1:0] p_data = '0;
    logic               i_rw, i_en;
    logic [A_WIDTH-1:0] b_addr;
    logic [D_WIDTH-1:0] t_out;
    logic               o_rw, o_en, busy, done;
`ifdef ATH_FGCOUNT_EN
    logic [A_WIDTH-1:0] fg_count;
`endif

    adaptive_threshold_engine #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .D_WIDTH(D_WIDTH),
        .A_WIDTH(A_WIDTH), .LOG_WIN(LOG_WIN)
    ) dut (
        .Clk(clk), .Rst(rst_n), .Go(go), .Thr_C(thr_c), .Inv(inv),
        .P_Addr(p_addr), .P_Data(p_data), .I_RW(i_rw), .I_En(i_en),
        .B_Addr(b_addr), .T_Out(t_out), .O_RW(o_rw), .O_En(o_en),
        .Busy(busy), .Done(done)
`ifdef ATH_FGCOUNT_EN
        , .Fg_Count(fg_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pixel SRAM: one-cycle read latency
    logic [D_WIDTH-1:0] mem [N];
    always @(posedge clk) begin
        if (i_en && !i_rw) p_data <= (p_addr < N) ? mem[p_addr] : '0;
    end

    typedef struct { int cyc; int addr; int data; } wr_t;
    typedef struct { int cyc; int fg; } dn_t;
    wr_t exp_q[$];
    dn_t done_q[$];
    int  busy_lo = -1000;
    int  busy_hi = -1000;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(string name, bit ok, longint act, longint exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference model: window of the current pixel and the WIN-1 before it in
    // the same row; positions left of column 0 take the row's first pixel.
    task automatic start_frame(input int c_val, input bit inv_val);
        int base, fgc, r, c, s, idx, mean, out;
        bit fg;
        thr_c = c_val[D_WIDTH-1:0];
        inv   = inv_val;
        go    = 1'b1;
        base  = cyc + 1;
        fgc   = 0;
        for (int k = 0; k < N; k++) begin
            r = k / IMG_W;
            c = k % IMG_W;
            s = 0;
            for (int j = 0; j < WIN; j++) begin
                idx = c - j;
                s += (idx >= 0) ? int'(mem[r*IMG_W + idx]) : int'(mem[r*IMG_W]);
            end
            mean = s / WIN;
            fg   = (int'(mem[k]) + c_val) > mean;
            out  = (fg != inv_val) ? 255 : 0;
            fgc += int'(fg);
            exp_q.push_back('{base + k + 2, k, out});
        end
        done_q.push_back('{base + N + 2, fgc});
        busy_lo = base;
        busy_hi = base + N + 1;
        @(posedge clk);
        #1 go = 1'b0;
    endtask

    // Runs out the frame; optionally toggles Go while Busy to show it is ignored.
    task automatic finish_frame(input bit noise);
        for (int i = 0; i < N + 6; i++) begin
            @(negedge clk);
            go = noise && (cyc <= busy_hi) && ($urandom_range(0, 2) == 0);
        end
        go = 1'b0;
        check("frame_writes_drained", exp_q.size() == 0, exp_q.size(), 0);
        check("frame_done_seen", done_q.size() == 0, done_q.size(), 0);
    endtask

    task automatic run_frame(input int c_val, input bit inv_val, input bit noise);
        @(negedge clk);
        start_frame(c_val, inv_val);
        finish_frame(noise);
    endtask

    task automatic check_reset_outputs(input string name);
        logic [47:0] v;
        v = {p_addr, b_addr, t_out, i_en, i_rw, o_en, o_rw, busy, done};
        check(name, v == '0, v, 0);
`ifdef ATH_FGCOUNT_EN
        check({name, "_fgcount"}, fg_count == '0, fg_count, 0);
`endif
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1'b0, b_addr, -1);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_cycle", cyc == e.cyc, cyc, e.cyc);
                    check("wr_addr", int'(b_addr) == e.addr, b_addr, e.addr);
                    check("wr_data", int'(t_out) == e.data, t_out, e.data);
                    check("wr_rw", o_rw == 1'b1, o_rw, 1);
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                check("missing_write", 1'b0, 0, exp_q[0].addr);
                void'(exp_q.pop_front());
            end

            check("busy", busy == (cyc >= busy_lo && cyc <= busy_hi), busy,
                  (cyc >= busy_lo && cyc <= busy_hi));
            check("i_en", i_en == (cyc >= busy_lo && cyc <= busy_lo + N - 1), i_en,
                  (cyc >= busy_lo && cyc <= busy_lo + N - 1));
            check("i_rw", i_rw == 1'b0, i_rw, 0);
            if (cyc >= busy_lo && cyc <= busy_lo + N - 1)
                check("p_addr", int'(p_addr) == cyc - busy_lo, p_addr, cyc - busy_lo);

            if (done_q.size() > 0 && done_q[0].cyc == cyc) begin
                dn_t d;
                d = done_q.pop_front();
                check("done_pulse", done == 1'b1, done, 1);
`ifdef ATH_FGCOUNT_EN
                check("fg_count", int'(fg_count) == d.fg, fg_count, d.fg);
`endif
            end else if (done) begin
                check("unexpected_done", 1'b0, done, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        go    = 1'b0;
        thr_c = '0;
        inv   = 1'b0;
        #1 check_reset_outputs("reset_state");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Flat frame, C=0 then C=1
        for (int k = 0; k < N; k++) mem[k] = 8'd100;
        run_frame(0, 1'b0, 1'b0);
        run_frame(1, 1'b0, 1'b0);

        // Step edge within a row, normal and inverted
        for (int k = 0; k < N; k++) mem[k] = ((k % IMG_W) < 4) ? 8'd0 : 8'd200;
        run_frame(0, 1'b0, 1'b0);
        run_frame(0, 1'b1, 1'b0);

        // Bright row then dark row: window must reload at the row start
        for (int k = 0; k < N; k++) mem[k] = (k < IMG_W) ? 8'd200 : 8'd10;
        run_frame(0, 1'b0, 1'b0);

        // Go while busy, then reset mid-frame, then an immediate new frame
        for (int k = 0; k < N; k++) mem[k] = 8'd100;
        @(negedge clk);
        start_frame(1, 1'b0);
        for (int i = 0; i < 20 && cyc < busy_lo + 5; i++) @(negedge clk);
        go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        for (int i = 0; i < 20 && cyc < busy_lo + 8; i++) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        done_q.delete();
        busy_lo = -1000;
        busy_hi = -1000;
        #1 check_reset_outputs("abort_reset");
        repeat (2) @(negedge clk);
        check_reset_outputs("held_reset");
        rst_n = 1'b1;
        start_frame(1, 1'b0);
        finish_frame(1'b0);

        // Randomized frames with Go noise while busy
        for (int f = 0; f < 8; f++) begin
            int cv;
            for (int k = 0; k < N; k++) mem[k] = D_WIDTH'($urandom_range(0, 255));
            cv = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
            run_frame(cv, 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adaptive_threshold_engine.md
ADAPTIVE_THRESHOLD_ENGINE -- requirements
Module: adaptive_threshold_engine

Interface
REQ-001 Parameters SHALL be: IMG_W default 320, row length in pixels; IMG_H default 240, row count; D_WIDTH default 8, pixel width; A_WIDTH default 17, SRAM address width, at least ceil(log2(IMG_W*IMG_H)); LOG_WIN default 3, log2 of window length, legal range 1..5.
REQ-002 Clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Rst  input  1  asynchronous, active-low reset.
REQ-004 Go  input  1  start request, sampled on the rising edge.
REQ-005 Thr_C  input  D_WIDTH  offset C, latched on an accepted Go.
REQ-006 Inv  input  1  inverse-output mode, latched on an accepted Go.
REQ-007 P_Addr  output  A_WIDTH  pixel SRAM address.
REQ-008 P_Data  input  D_WIDTH  pixel SRAM read data; valid one cycle after address and enable are presented.
REQ-009 I_RW, I_En  output  1 each  pixel SRAM control; RW=1 means write, RW=0 means read.
REQ-010 B_Addr, T_Out  output  A_WIDTH, D_WIDTH  result SRAM address and write data.
REQ-011 O_RW, O_En  output  1 each  result SRAM control, same encoding as REQ-009.
REQ-012 Busy, Done  output  1 each  frame in progress; one-cycle completion pulse.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and FLUSH. IDLE moves to RUN on Go=1. RUN moves to FLUSH after issuing address N-1, where N = IMG_W*IMG_H. FLUSH moves to IDLE after the last write.
REQ-014 Go SHALL be ignored while Busy=1.
REQ-015 In RUN cycle k (k = 0..N-1), the block SHALL drive P_Addr=k, I_En=1 and I_RW=0, reading one pixel per cycle.
REQ-016 The result for pixel k SHALL be presented in cycle k+2: B_Addr=k, O_En=1, O_RW=1, T_Out=result.
REQ-017 Done SHALL pulse in cycle N+2 and then Busy SHALL fall; Busy SHALL be 1 from cycle 0 through cycle N+1.
REQ-018 The window SHALL be the current pixel plus the previous 2^LOG_WIN-1 pixels of the same row, held in a shift register with a running sum of width D_WIDTH+LOG_WIN.
REQ-019 At column 0 of every row, every shift-register entry SHALL be loaded with p0, the first pixel of that row, and the sum SHALL be set to p0<<LOG_WIN; the window never spans rows.
REQ-020 For columns above 0, the update SHALL be sum = sum + p - oldest, and mean = sum>>LOG_WIN (truncating).
REQ-021 The foreground test SHALL be (p + C) > mean, evaluated at D_WIDTH+1 bits with no underflow or overflow.
REQ-022 With Inv=0, foreground SHALL give T_Out={D_WIDTH{1}} and background SHALL give 0; Inv=1 SHALL swap the two values.
REQ-023 The column and row counters SHALL wrap at IMG_W-1 and IMG_H-1 respectively; the address counter SHALL not wrap within a frame.
REQ-024 When I_En and O_En are 0, P_Addr, B_Addr and T_Out SHALL hold their last values.

Reset
REQ-025 When Rst=0, the block SHALL immediately and asynchronously enter IDLE and force every output to 0: I_En, O_En, I_RW, O_RW, Busy, Done, P_Addr, B_Addr, T_Out.
REQ-026 A reset during RUN or FLUSH SHALL abort the frame; the result SRAM keeps any partial writes, and no Done SHALL be produced.
REQ-027 After Rst returns to 1, the block SHALL accept the first Go on the following rising edge.

Configuration
REQ-028 With macro ATH_FGCOUNT_EN defined, the block SHALL add output Fg_Count (A_WIDTH bits): it is cleared on an accepted Go, increments on each foreground write, and holds its value after Done. It resets to 0.
REQ-029 With ATH_FGCOUNT_EN undefined, the Fg_Count port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Settings: IMG_W=8, IMG_H=2, LOG_WIN=2, C=0, Inv=0, every pixel 100. Required: all 16 outputs 0 (100>100 is false); Done in cycle 18; with the macro, Fg_Count=0.
REQ-031 Same settings with C=1. Required: all 16 outputs 255; with the macro, Fg_Count=16.
REQ-032 Row 0 = 0,0,0,0,200,200,200,200; C=0. Required: outputs 0,0,0,0,255,255,255,0. The last mean is 200, so 200>200 is false.
REQ-033 Row 0 all 200, row 1 all 10, C=0. Required: row 1, column 0 outputs 0, proving the window reloads at the row start and does not mix in row 0.
REQ-034 Go pulsed again at cycle 5, then Rst=0 at cycle 9. Required: the second Go is ignored; after reset all outputs are 0 and no Done is produced; a new Go then completes a full frame correctly.
REQ-035 REQ-032 repeated with Inv=1. Required: outputs 255,255,255,255,0,0,0,255.
